// File: rtl/game_pkg.sv
// Shared definitions for the bouncing-ball round sequencer: phase encoding,
// elasticity/difficulty limits and the screen-coordinate type.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    MISS  = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam logic [1:0] K_START   = 2'd3;
  localparam logic [1:0] MAX_LEVEL = 2'd3;

  typedef logic [8:0] coord_t;

endpackage

// File: rtl/tick_rise_detect.sv
// One-tick rising-edge pulse on a level input, sampled on the physics tick.
module tick_rise_detect (
  input  logic clk_out,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_round_sequencer.sv
// Round controller for the bouncing-ball game: serve/play/miss/game-over phases,
// score, lives and difficulty. Optional high-score tracking under HIGH_SCORE_EN.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int         LIVES_INIT = 3,
  parameter int         SCORE_W    = 10,
  parameter int         LEVEL_STEP = 5,
  parameter logic [1:0] K_START    = game_pkg::K_START,
  parameter int         HOME_Y     = 20,
  parameter int         ARM_TICKS  = 4,
  parameter int         MISS_TICKS = 55
) (
  input  logic               clk_out,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               catch_evt,
  input  logic               over_flag,
  output logic               ball_release_n,
  output logic [1:0]         k_sel,
  output logic [8:0]         home,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [1:0]         level,
  output logic [2:0]         phase,
`ifdef HIGH_SCORE_EN
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_record,
`endif
  output logic               game_over
);

  localparam int CNT_MAX = (MISS_TICKS > ARM_TICKS) ? MISS_TICKS : ARM_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STEP_W  = $clog2(LEVEL_STEP + 1);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [STEP_W-1:0]  r_step;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic [1:0]         r_level;
  logic [1:0]         r_k_sel;

  // bit 0: start_btn, bit 1: catch_evt
  logic [1:0] w_src, w_rise;
  logic       w_start_rise, w_catch_rise, w_catch_ok, w_restart;

  assign w_src = {catch_evt, start_btn};

  for (genvar g = 0; g < 2; g++) begin : g_rise
    tick_rise_detect u_rise (
      .clk_out (clk_out),
      .reset   (reset),
      .i_d     (w_src[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_start_rise = w_rise[0];
  assign w_catch_rise = w_rise[1];

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start_rise) w_next = ARM;
      ARM:   if (r_cnt == CNT_W'(ARM_TICKS - 1)) w_next = SERVE;
      SERVE: w_next = PLAY;
      PLAY:  if (over_flag) w_next = MISS;
      // lives were already decremented on the way in
      MISS: begin
        if (r_lives == 3'd0)                       w_next = OVER;
        else if (r_cnt == CNT_W'(MISS_TICKS - 1))  w_next = ARM;
      end
      OVER:  if (w_start_rise) w_next = ARM;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ball_release_n = 1'b0;
    game_over      = 1'b0;
    phase          = r_state;
    if (r_state == SERVE || r_state == PLAY) ball_release_n = 1'b1;
    if (r_state == OVER)                     game_over      = 1'b1;
  end

  // Tick counter restarts on every phase change, so ARM and MISS each count from 0.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset)                                   r_cnt <= '0;
    else if (w_next != r_state)                   r_cnt <= '0;
    else if (r_state == ARM || r_state == MISS)   r_cnt <= r_cnt + 1'b1;
  end

  // A miss in the same tick as a catch wins; that catch is dropped.
  assign w_catch_ok = (r_state == PLAY) && w_catch_rise && !over_flag;
  assign w_restart  = (r_state == OVER) && w_start_rise;

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      r_score <= '0;
      r_lives <= 3'(LIVES_INIT);
      r_level <= '0;
      r_k_sel <= K_START;
      r_step  <= '0;
    end else if (w_restart) begin
      r_score <= '0;
      r_lives <= 3'(LIVES_INIT);
      r_level <= '0;
      r_k_sel <= K_START;
      r_step  <= '0;
    end else begin
      if (r_state == PLAY && over_flag && r_lives != 3'd0)
        r_lives <= r_lives - 3'd1;
      if (w_catch_ok) begin
        if (r_score != '1) r_score <= r_score + 1'b1;
        if (r_step == STEP_W'(LEVEL_STEP - 1)) begin
          r_step <= '0;
          if (r_level != MAX_LEVEL) r_level <= r_level + 2'd1;
          if (r_k_sel != 2'd0)      r_k_sel <= r_k_sel - 2'd1;
        end else begin
          r_step <= r_step + 1'b1;
        end
      end
    end
  end

  assign k_sel = r_k_sel;
  assign score = r_score;
  assign lives = r_lives;
  assign level = r_level;
  assign home  = coord_t'(HOME_Y);

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_hi_score;
  logic               r_new_record;

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      r_hi_score   <= '0;
      r_new_record <= 1'b0;
    end else begin
      r_new_record <= 1'b0;
      if (w_next == OVER && r_state != OVER && r_score > r_hi_score) begin
        r_hi_score   <= r_score;
        r_new_record <= 1'b1;
      end
    end
  end

  assign hi_score   = r_hi_score;
  assign new_record = r_new_record;
`endif

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer; covers HIGH_SCORE_EN when defined.
module tb_game_round_sequencer;

  logic       clk_out   = 1'b0;
  logic       reset     = 1'b0;
  logic       start_btn = 1'b0;
  logic       catch_evt = 1'b0;
  logic       over_flag = 1'b0;
  logic       ball_release_n;
  logic [1:0] k_sel;
  logic [8:0] home;
  logic [9:0] score;
  logic [2:0] lives;
  logic [1:0] level;
  logic [2:0] phase;
  logic       game_over;
`ifdef HIGH_SCORE_EN
  logic [9:0] hi_score;
  logic       new_record;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_out = ~clk_out;

  game_round_sequencer dut (
    .clk_out        (clk_out),
    .reset          (reset),
    .start_btn      (start_btn),
    .catch_evt      (catch_evt),
    .over_flag      (over_flag),
    .ball_release_n (ball_release_n),
    .k_sel          (k_sel),
    .home           (home),
    .score          (score),
    .lives          (lives),
    .level          (level),
    .phase          (phase),
`ifdef HIGH_SCORE_EN
    .hi_score       (hi_score),
    .new_record     (new_record),
`endif
    .game_over      (game_over)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_out);
      @(negedge clk_out);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_catch();
    catch_evt = 1'b1;
    step(3);
    catch_evt = 1'b0;
    step(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"}, 32'(phase), 0);
    check({tag, "_brn"},   32'(ball_release_n), 0);
    check({tag, "_ksel"},  32'(k_sel), 3);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_lives"}, 32'(lives), 3);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_gover"}, 32'(game_over), 0);
    check({tag, "_home"},  32'(home), 20);
`ifdef HIGH_SCORE_EN
    check({tag, "_hi"},    32'(hi_score), 0);
    check({tag, "_newrec"}, 32'(new_record), 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk_out);
    check_reset_vals("rst");

    reset = 1'b1;
    step(2);
    check("idle_hold", 32'(phase), 0);

    // serve: ARM for 4 ticks, SERVE, then PLAY
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    check("arm_enter", 32'(phase), 1);
    check("arm_brn", 32'(ball_release_n), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("arm_hold", 32'(phase), 1);
    end
    step(1);
    check("serve_phase", 32'(phase), 2);
    check("serve_brn", 32'(ball_release_n), 1);
    step(1);
    check("play_phase", 32'(phase), 3);
    check("play_brn", 32'(ball_release_n), 1);

    // difficulty steps and saturation
    repeat (5) do_catch();
    check("c5_score", 32'(score), 5);
    check("c5_level", 32'(level), 1);
    check("c5_ksel",  32'(k_sel), 2);
    repeat (15) do_catch();
    check("c20_score", 32'(score), 20);
    check("c20_level", 32'(level), 3);
    check("c20_ksel",  32'(k_sel), 0);
    repeat (5) do_catch();
    check("c25_score", 32'(score), 25);
    check("c25_level", 32'(level), 3);
    check("c25_ksel",  32'(k_sel), 0);

    // first miss: 55-tick pause then re-arm
    over_flag = 1'b1;
    step(1);
    over_flag = 1'b0;
    check("miss1_phase", 32'(phase), 4);
    check("miss1_lives", 32'(lives), 2);
    check("miss1_brn",   32'(ball_release_n), 0);
    step(54);
    check("miss1_last", 32'(phase), 4);
    step(1);
    check("miss1_rearm", 32'(phase), 1);
    check("miss1_score", 32'(score), 25);
    check("miss1_level", 32'(level), 3);
    step(5);
    check("play2_phase", 32'(phase), 3);

    // over_flag and catch rise together: catch dropped
    over_flag = 1'b1;
    catch_evt = 1'b1;
    step(1);
    over_flag = 1'b0;
    catch_evt = 1'b0;
    check("both_score", 32'(score), 25);
    check("both_lives", 32'(lives), 1);
    check("both_phase", 32'(phase), 4);
    step(60);
    check("play3_phase", 32'(phase), 3);

    // third miss -> game over
    over_flag = 1'b1;
    step(1);
    over_flag = 1'b0;
    check("miss3_lives", 32'(lives), 0);
    check("miss3_phase", 32'(phase), 4);
    step(1);
    check("over_phase", 32'(phase), 5);
    check("over_flag_out", 32'(game_over), 1);
    check("over_brn", 32'(ball_release_n), 0);
    check("over_score", 32'(score), 25);
`ifdef HIGH_SCORE_EN
    check("g1_hi", 32'(hi_score), 25);
    check("g1_newrec", 32'(new_record), 1);
    step(1);
    check("g1_newrec_pulse", 32'(new_record), 0);
    check("g1_hi_hold", 32'(hi_score), 25);
`endif

    // restart
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    check("rs_score", 32'(score), 0);
    check("rs_lives", 32'(lives), 3);
    check("rs_ksel",  32'(k_sel), 3);
    check("rs_level", 32'(level), 0);
    check("rs_phase", 32'(phase), 1);
    check("rs_gover", 32'(game_over), 0);
    step(5);
    check("rs_play", 32'(phase), 3);

`ifdef HIGH_SCORE_EN
    // lower-scoring second game must not replace the record
    repeat (4) do_catch();
    repeat (2) begin
      over_flag = 1'b1;
      step(1);
      over_flag = 1'b0;
      step(60);
    end
    over_flag = 1'b1;
    step(1);
    over_flag = 1'b0;
    step(1);
    check("g2_phase", 32'(phase), 5);
    check("g2_score", 32'(score), 4);
    check("g2_hi", 32'(hi_score), 25);
    check("g2_newrec", 32'(new_record), 0);
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(5);
    check("g3_play", 32'(phase), 3);
`endif

    // asynchronous reset in the middle of PLAY
    do_catch();
    check("pre_rst_score", 32'(score), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk_out);
    reset = 1'b1;
    step(1);
    check("post_rst_idle", 32'(phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
